// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: control-bit positions, datapath widths
// and the MEM-stage access FSM states.
package mips_pkg;

    localparam int unsigned M_BRANCH    = 2;
    localparam int unsigned M_MEMREAD   = 1;
    localparam int unsigned M_MEMWRITE  = 0;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write with enable, asynchronous read.
module data_memory
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with wait states, branch resolution and
// the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        WB,
    input  logic [2:0]        M,
    input  logic [WORD_W-1:0] PC,
    input  logic              zero,
    input  logic [WORD_W-1:0] ALUresult,
    input  logic [WORD_W-1:0] writeData,
    input  logic [REG_W-1:0]  writeRegister,
    input  logic              flush,
    output logic              stall,
    output logic              PCSrc,
    output logic [WORD_W-1:0] branchTarget,
    output logic [1:0]        WB_output,
    output logic [WORD_W-1:0] readData_output,
    output logic [WORD_W-1:0] ALUresult_output,
    output logic [REG_W-1:0]  writeRegister_output,
    output logic              misalign,
    output logic              illegal
);

    localparam int unsigned CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        wb_q, wb_d;
    logic [WORD_W-1:0] rd_q, rd_d;
    logic [WORD_W-1:0] alu_q, alu_d;
    logic [REG_W-1:0]  wr_q, wr_d;
    logic              mis_q, mis_d;
    logic              illegal_q, illegal_d;

    logic              mem_op;
    logic              is_load;
    logic              both_set;
    logic              complete;
    logic              stall_raw;
    logic              mem_we;
    logic [ADDR_W-1:0] word_idx;
    logic [WORD_W-1:0] mem_rdata;

    assign mem_op   = M[M_MEMREAD] | M[M_MEMWRITE];
    assign both_set = M[M_MEMREAD] & M[M_MEMWRITE];
    assign is_load  = M[M_MEMREAD] & ~M[M_MEMWRITE];
    assign word_idx = ALUresult[ADDR_W+1:2];

    // Access FSM: decides when the stage stalls and when the op is allowed to retire.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        complete  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!mem_op) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = '0;
        end else if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    stall_raw = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = CNT_W'(WAIT_LOAD);
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        stall_raw = 1'b1;
                        cnt_d     = cnt_q - 1'b1;
                    end else begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign mem_we = complete & M[M_MEMWRITE];

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (writeData),
        .rdata_o (mem_rdata)
    );

    // MEM/WB register: the retiring instruction on completion, a bubble otherwise.
    always_comb begin
        wb_d  = '0;
        rd_d  = '0;
        alu_d = '0;
        wr_d  = '0;
        mis_d = 1'b0;
        if (complete) begin
            wb_d  = WB;
            rd_d  = is_load ? mem_rdata : '0;
            alu_d = ALUresult;
            wr_d  = writeRegister;
            mis_d = mem_op & (ALUresult[1:0] != 2'b00);
        end
        illegal_d = illegal_q | both_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wb_q      <= '0;
            rd_q      <= '0;
            alu_q     <= '0;
            wr_q      <= '0;
            mis_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_q      <= wb_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            wr_q      <= wr_d;
            mis_q     <= mis_d;
            illegal_q <= illegal_d;
        end
    end

    // Held-in-reset stage must not freeze upstream even if a memory op is presented.
    assign stall                = stall_raw & rst_n;
    assign PCSrc                = M[M_BRANCH] & zero & ~flush;
    assign branchTarget         = PC;
    assign WB_output            = wb_q;
    assign readData_output      = rd_q;
    assign ALUresult_output     = alu_q;
    assign writeRegister_output = wr_q;
    assign misalign             = mis_q;
    assign illegal              = illegal_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs and performs the data-memory load or store.
- Resolves the branch decision (PCSrc) for the fetch stage.
- Registers results into the MEM/WB pipeline register feeding write-back.
- Data memory has configurable wait states. The stage stalls upstream while an access is outstanding.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory.
- ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W.
- WAIT_CYCLES, 2, extra cycles per memory access; 0 gives single-cycle access.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WB  in  2  WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg.
- M  in  3  MEM control; [2]=Branch, [1]=MemRead, [0]=MemWrite.
- PC  in  32  branch target from EX/MEM.
- zero  in  1  ALU zero flag.
- ALUresult  in  32  byte address, or value passed to write-back.
- writeData  in  32  store data.
- writeRegister  in  5  destination register.
- flush  in  1  squash current instruction.
- stall  out  1  hold EX/MEM and earlier stages.
- PCSrc  out  1  take-branch select to fetch.
- branchTarget  out  32  equals PC.
- WB_output  out  2  registered WB control to MEM/WB.
- readData_output  out  32  registered load data.
- ALUresult_output  out  32  registered ALUresult.
- writeRegister_output  out  5  registered destination register.
- misalign  out  1  one-cycle pulse: access with ALUresult[1:0] != 0.
- illegal  out  1  sticky: MemRead and MemWrite both set.

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0, FSM in IDLE, wait counter 0, illegal 0. Memory contents are not reset.
- Memory op = MemRead | MemWrite. Word index = ALUresult[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH. Misaligned addresses use the truncated index and pulse misalign for 1 cycle on the completion edge.
- Non-memory op: no stall. The MEM/WB registers capture WB, ALUresult and writeRegister on the next rising edge; readData_output = 0.
- Memory op with WAIT_CYCLES=0: completes on the first edge. A store writes memory at that edge; a load captures memory[index] into readData_output.
- Memory op with WAIT_CYCLES=N>0, FSM IDLE -> WAIT -> IDLE:
  - IDLE with a memory op: stall=1 (combinational). Counter loads N-1 and the FSM enters WAIT.
  - WAIT: stall=1 while counter != 0; counter decrements each cycle.
  - Completion cycle (WAIT with counter == 0): stall=0. On that edge the store or load is performed, MEM/WB is updated and the FSM returns to IDLE.
  - Total occupancy is N+1 cycles.
- While stall=1: MEM/WB captures a bubble (WB_output=00, others 0). Upstream holds all inputs stable.
- Store commits exactly once per instruction, only on the completion edge.
- MemRead & MemWrite both set: treated as a store. readData_output = 0, illegal set and held until reset.
- PCSrc = Branch & zero & ~flush, combinational. Branch is never combined with a memory op.
- flush=1 in any cycle: FSM -> IDLE, counter cleared, no memory write, MEM/WB captures a bubble. stall=0 in that cycle.
- Reset mid-access: access is abandoned, no write is committed.
- Back-to-back memory ops: the second op enters IDLE->WAIT on the cycle after the first completes. There are no idle gap cycles.

Decomposition:
- mips_pkg holds:
  - M bit indices (M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0).
  - WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0).
  - FSM state encoding (ST_IDLE, ST_WAIT).
  - Word width 32 and register-index width 5.
- Sub-module data_memory: DEPTH x 32, synchronous write with a write-enable, asynchronous read. It is instantiated once inside mem_stage.

Test Plan:
- WAIT_CYCLES=2. Store M=001, ALUresult=0x10, writeData=0xDEADBEEF, then load M=010 at 0x10 with WB=11, writeRegister=5 -> store: stall high for 2 cycles, exactly one write; load: readData_output=0xDEADBEEF, WB_output=11, writeRegister_output=5 after 3 cycles.
- R-type WB=10, M=000, ALUresult=0x7 -> no stall; next edge ALUresult_output=0x7, readData_output=0.
- Branch M=100, zero=1, PC=0x40 -> PCSrc=1 and branchTarget=0x40 in the same cycle. With zero=0 -> PCSrc=0.
- Store to 0x20 with flush asserted in the second stall cycle -> no write; later load of 0x20 returns its prior value; WB_output=00 bubble after flush.
- Assert rst_n=0 mid-load -> all outputs 0 immediately, stall=0, FSM IDLE. Load to 0x402 with DEPTH=256 -> reads word 0, misalign pulses.
- M=011 -> illegal=1 and stays 1; write performed; readData_output=0.
